trainled2_tx: RTL and testbench
===============================

Name: trainled2_tx

Overview:
- Transmitter/controller for the TrainLED2 one-wire daisy-chain protocol.
- Accepts a stream of per-node colour words (led1/led2/led3, 8 bits each) over a valid/ready handshake.
- Serialises the words MSB first as pulse-width-coded bits on a single wire. That wire drives the first node's din.
- Ends every frame with a low latch gap so all nodes update their LED outputs.

Parameters:
- DATA_W, 24, bits per node word (led1[23:16], led2[15:8], led3[7:0]).
- BIT_CYCLES, 24, clock cycles per bit period.
- T0H, 6, high cycles for a '0' bit.
- T1H, 16, high cycles for a '1' bit.
- LATCH_CYCLES, 500, low cycles of the end-of-frame latch gap.
- Legal ranges: 0 < T0H < T1H < BIT_CYCLES; LATCH_CYCLES > 2*BIT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- word_data  in  DATA_W  node word, MSB transmitted first.
- word_valid  in  1  word_data/word_last valid.
- word_last  in  1  current word is the final node word of the frame.
- word_ready  out  1  transmitter accepts word this cycle (handshake = valid & ready).
- dout  out  1  serial line to first node din.
- busy  out  1  frame in progress (any state other than IDLE).
- frame_done  out  1  one-cycle pulse at end of latch gap.
- underrun  out  1  one-cycle pulse when the next word is missing at a word boundary.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: dout=0, busy=0, frame_done=0, underrun=0, state=IDLE. word_ready=0 while rst=1.
- Reset mid-frame: dout goes 0 at the next edge. The current word and bit counters are discarded, with no latch gap and no frame_done.
- States: IDLE, BIT, LATCH.
- IDLE:
  - word_ready=1, dout=0.
  - On handshake at edge k: load shift register with word_data and capture last_q=word_last.
  - Go to BIT with bit_idx=DATA_W-1 and cycle counter cnt=0.
  - dout is high from the cycle after edge k (registered output).
- BIT:
  - Each bit lasts exactly BIT_CYCLES cycles.
  - dout=1 for cnt < TH, else 0, where TH=T1H if the current bit is 1, otherwise T0H.
  - When cnt=BIT_CYCLES-1, cnt wraps to 0 and the next lower bit starts.
- Word boundary (bit_idx=0, cnt=BIT_CYCLES-1):
  - last_q=1: go to LATCH.
  - last_q=0: word_ready=1 in this cycle only.
    - If word_valid=1: load the new word and continue with its MSB on the next cycle. The line shows no gap between words.
    - If word_valid=0: pulse underrun and go to LATCH. The frame ends early and the already-sent nodes latch.
- word_ready is 0 in all other BIT cycles and in all LATCH cycles. word_valid outside ready windows is ignored.
- LATCH:
  - dout=0 for LATCH_CYCLES cycles.
  - In the final cycle frame_done=1, then go to IDLE.
  - A word presented during LATCH waits; it is accepted in IDLE.
- Timing:
  - Frame of N words, from the first handshake edge to the frame_done pulse cycle: N*DATA_W*BIT_CYCLES + LATCH_CYCLES cycles.
  - Next frame earliest start: the cycle after frame_done (IDLE, ready=1).
- Counters: cnt width clog2(max(BIT_CYCLES, LATCH_CYCLES)); bit_idx width clog2(DATA_W). No overflow is possible within legal parameters.
- busy=1 from the cycle after the first handshake through the frame_done cycle inclusive.
- dout is driven directly from a flop; no combinational glitches.

Test Plan:
- Reset: hold rst 3 cycles with word_valid=1 → dout=0, word_ready=0, busy=0. After release, word_ready=1 in the first cycle.
- Single word 0xA50F01, last=1:
  - Bit 23 ('1'): dout high 16 cycles, low 8. Bit 22 ('0'): high 6, low 18.
  - After 576 cycles dout is low for 500 cycles, then frame_done pulses once at cycle 1076.
  - A bench-decoded stream equals 0xA50F01.
- Three-word frame 0xFF0000, 0x00FF00, 0x0000FF (last on the third), word_valid held high:
  - word_ready is seen only in IDLE and at the two boundaries.
  - Continuous bit timing with no gaps.
  - frame_done at 3*576+500 = 2228 cycles.
  - A chain of 3 TrainLED2 models shows led1/led2/led3 = node0 red, node1 green, node2 blue.
- Underrun: word 0x123456 with last=0, then word_valid=0 at the boundary → underrun pulses at cycle 576, LATCH 500 cycles, frame_done, return to IDLE.
- Reset mid-frame: assert rst during bit 10 of word 1 → dout=0 next edge, busy=0, no frame_done. A new frame afterwards transmits correctly from its MSB.
- Back-to-back frames: present a second frame during LATCH of the first → its word is accepted only in the IDLE cycle after frame_done. The first bit rises one cycle later; latch gap ≥500 cycles is preserved.

Source files
------------

// File: rtl/trainled2_tx.sv
// -----------------------------------------------------------------------------
// trainled2_tx
//   Transmitter for the TrainLED2 one-wire daisy chain. Node words arrive on a
//   valid/ready handshake. Each word is sent MSB first, and every bit is a
//   pulse-width-coded period of BIT_CYCLES clocks: high for T1H clocks for a
//   '1' and for T0H clocks for a '0', then low. Consecutive words of a frame
//   follow each other with no gap. A frame ends with LATCH_CYCLES of low line
//   so that every node in the chain updates its LED outputs.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   word_data   node word {led1, led2, led3}, MSB sent first
//   word_valid  word_data / word_last are valid
//   word_last   current word is the final node word of the frame
//   word_ready  a word is taken this cycle when word_valid is also high
//   dout        serial line to the first node's din (driven from a flop)
//   busy        frame in progress (state other than IDLE)
//   frame_done  one-cycle pulse in the last cycle of the latch gap
//   underrun    one-cycle pulse when no word is offered at a word boundary
// -----------------------------------------------------------------------------
module trainled2_tx #(
    parameter int DATA_W       = 24,
    parameter int BIT_CYCLES   = 24,
    parameter int T0H          = 6,
    parameter int T1H          = 16,
    parameter int LATCH_CYCLES = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] word_data,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              word_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int CNT_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_PRE  = CNT_W'(LATCH_CYCLES - 2);
    localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(T1H);
    localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIT,
        S_LATCH
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shift_q;   // current bit is always shift_q[DATA_W-1]
    logic                last_q;
    logic [IDX_W-1:0]    bit_idx;
    logic [CNT_W-1:0]    cnt;

    logic                at_boundary;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    th_cur;

    assign at_boundary = (state == S_BIT) && (bit_idx == '0) && (cnt == BIT_LAST);
    assign cnt_inc     = cnt + 1'b1;
    assign th_cur      = shift_q[DATA_W-1] ? T1H_C : T0H_C;

    // NOTE: word_ready and underrun are decoded from registered state (plus
    // word_valid) rather than registered themselves: the ready window is the
    // single boundary cycle, and the underrun decision is only known in that
    // same cycle, so a flop would report it one cycle late.
    assign word_ready = !rst && ((state == S_IDLE) || (at_boundary && !last_q));
    assign underrun   = !rst && at_boundary && !last_q && !word_valid;
    assign busy       = (state != S_IDLE);

    // dout is computed for the cycle that follows each edge, so the line is
    // a plain flop output with the pulse aligned to cnt of that cycle.
    // NOTE: all state here uses non-blocking assignments so every branch reads
    // the pre-edge values of cnt, bit_idx and shift_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shift_q    <= '0;
            last_q     <= 1'b0;
            bit_idx    <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    dout <= 1'b0;
                    if (word_valid) begin
                        shift_q <= word_data;
                        last_q  <= word_last;
                        bit_idx <= IDX_MSB;
                        cnt     <= '0;
                        dout    <= 1'b1;   // T0H > 0, so every bit starts high
                        state   <= S_BIT;
                    end
                end

                S_BIT: begin
                    if (cnt != BIT_LAST) begin
                        cnt  <= cnt_inc;
                        dout <= (cnt_inc < th_cur);
                    end else if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        shift_q <= shift_q << 1;
                        cnt     <= '0;
                        dout    <= 1'b1;
                    end else if (!last_q && word_valid) begin
                        // Next word follows seamlessly with its MSB.
                        shift_q <= word_data;
                        last_q  <= word_last;
                        bit_idx <= IDX_MSB;
                        cnt     <= '0;
                        dout    <= 1'b1;
                    end else begin
                        // Either the frame ended normally or the source ran
                        // dry; in both cases the sent nodes must latch.
                        cnt   <= '0;
                        dout  <= 1'b0;
                        state <= S_LATCH;
                    end
                end

                S_LATCH: begin
                    dout <= 1'b0;
                    if (cnt == LATCH_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt        <= cnt_inc;
                        frame_done <= (cnt == LATCH_PRE);
                    end
                end

                default: begin
                    dout  <= 1'b0;
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trainled2_tx.sv
// -----------------------------------------------------------------------------
// tb_trainled2_tx
//   Directed bench for trainled2_tx with default parameters (24-bit words,
//   24-cycle bits, 6/16 high times, 500-cycle latch gap). The dout line is
//   recorded cycle by cycle, decoded back into words and pulse shapes, and
//   compared with hand-computed constants.
//   Cycle numbering inside a frame: cycle 1 is the cycle after the first
//   handshake edge; a frame of N words ends with frame_done in cycle
//   N*576 + 500.
// -----------------------------------------------------------------------------
module tb_trainled2_tx;

    logic        clk;
    logic        rst;
    logic [23:0] word_data;
    logic        word_valid;
    logic        word_last;
    logic        word_ready;
    logic        dout;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    trainled2_tx dut (
        .clk        (clk),
        .rst        (rst),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_last  (word_last),
        .word_ready (word_ready),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-frame capture and results shared between run_frame and callers.
    logic        dout_log [0:2400];
    int          hc_log   [0:71];
    logic [23:0] fw       [0:3];
    logic [23:0] dec      [0:3];
    int          fd_cycle;
    int          fd_count;
    int          ur_cycle;
    int          ur_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends fw[0..n-1] starting from an IDLE cycle and records the frame up to
    // and including its frame_done cycle. final_last=0 leaves word_last low on
    // the final word so the frame ends by underrun. pend_* is what the source
    // offers once the frame's words are all taken.
    task automatic run_frame(input string name, input int n, input logic final_last,
                             input logic pend_valid, input logic [23:0] pend_word);
        int          total;
        int          idx;
        int          base;
        int          hc;
        int          shape_err;
        int          latch_err;
        int          ready_err;
        int          busy_err;
        logic        exp_ready;
        logic        bit_v;
        logic [23:0] word;

        total     = n * 576 + 500;
        shape_err = 0;
        latch_err = 0;
        ready_err = 0;
        busy_err  = 0;
        fd_cycle  = -1;
        fd_count  = 0;
        ur_cycle  = -1;
        ur_count  = 0;

        word_data  = fw[0];
        word_last  = (n == 1) && final_last;
        word_valid = 1'b1;
        #1;
        check({name, "_idle_ready"}, 32'(word_ready), 32'd1);

        for (int t = 1; t <= total; t++) begin
            step();
            // Right after a word is taken, offer the next one.
            if ((t - 1) % 576 == 0) begin
                idx = (t - 1) / 576 + 1;
                if (idx < n) begin
                    word_data  = fw[idx];
                    word_last  = (idx == n - 1) && final_last;
                    word_valid = 1'b1;
                end else begin
                    word_data  = pend_word;
                    word_last  = 1'b1;
                    word_valid = pend_valid;
                end
            end
            #1;
            dout_log[t] = dout;
            exp_ready = (t % 576 == 0) && (t <= n * 576) && ((t / 576 < n) || !final_last);
            if (word_ready !== exp_ready) ready_err++;
            if (busy !== 1'b1) busy_err++;
            if (frame_done === 1'b1) begin
                fd_count++;
                fd_cycle = t;
            end
            if (underrun === 1'b1) begin
                ur_count++;
                ur_cycle = t;
            end
        end

        // Decode each bit period: a clean pulse starts the period and is
        // exactly 6 or 16 cycles long.
        for (int w = 0; w < n; w++) begin
            word = '0;
            for (int b = 0; b < 24; b++) begin
                base = w * 576 + b * 24 + 1;
                hc = 0;
                for (int c = 0; c < 24; c++) if (dout_log[base + c] === 1'b1) hc++;
                for (int c = 0; c < 24; c++) if (dout_log[base + c] !== (c < hc)) shape_err++;
                if (hc != 6 && hc != 16) shape_err++;
                hc_log[w * 24 + b] = hc;
                bit_v = (hc == 16);
                word  = {word[22:0], bit_v};
            end
            dec[w] = word;
        end
        for (int t = n * 576 + 1; t <= total; t++) if (dout_log[t] !== 1'b0) latch_err++;

        check({name, "_bit_shape_errs"}, 32'(shape_err), 32'd0);
        check({name, "_latch_low_errs"}, 32'(latch_err), 32'd0);
        check({name, "_ready_window_errs"}, 32'(ready_err), 32'd0);
        check({name, "_busy_errs"}, 32'(busy_err), 32'd0);
        check({name, "_frame_done_pulses"}, 32'(fd_count), 32'd1);
    endtask

    logic [7:0] exp_led [0:2][0:2];
    int         fd_seen;
    int         hi_seen;

    initial begin
        rst        = 1'b1;
        word_data  = 24'h000000;
        word_valid = 1'b1;
        word_last  = 1'b0;

        // ---------------- reset ----------------
        repeat (3) step();
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ready", 32'(word_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(word_ready), 32'd1);
        word_valid = 1'b0;
        step();

        // ---------------- single word ----------------
        fw[0] = 24'hA50F01;
        run_frame("single", 1, 1'b1, 1'b0, 24'h000000);
        check("single_fd_cycle", 32'(fd_cycle), 32'd1076);
        check("single_underrun_pulses", 32'(ur_count), 32'd0);
        check("single_bit23_high", 32'(hc_log[0]), 32'd16);
        check("single_bit22_high", 32'(hc_log[1]), 32'd6);
        check("single_decoded", 32'(dec[0]), 32'h00A50F01);
        step();
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_idle_frame_done", 32'(frame_done), 32'd0);

        // ---------------- three-word frame ----------------
        fw[0] = 24'hFF0000;
        fw[1] = 24'h00FF00;
        fw[2] = 24'h0000FF;
        run_frame("three", 3, 1'b1, 1'b0, 24'h000000);
        check("three_fd_cycle", 32'(fd_cycle), 32'd2228);
        check("three_underrun_pulses", 32'(ur_count), 32'd0);
        // Daisy chain: node i keeps the i-th 24 bits of the stream.
        exp_led[0][0] = 8'hFF; exp_led[0][1] = 8'h00; exp_led[0][2] = 8'h00;
        exp_led[1][0] = 8'h00; exp_led[1][1] = 8'hFF; exp_led[1][2] = 8'h00;
        exp_led[2][0] = 8'h00; exp_led[2][1] = 8'h00; exp_led[2][2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("node%0d_led1", i), 32'(dec[i][23:16]), 32'(exp_led[i][0]));
            check($sformatf("node%0d_led2", i), 32'(dec[i][15:8]),  32'(exp_led[i][1]));
            check($sformatf("node%0d_led3", i), 32'(dec[i][7:0]),   32'(exp_led[i][2]));
        end
        step();
        check("three_idle_busy", 32'(busy), 32'd0);

        // ---------------- underrun ----------------
        fw[0] = 24'h123456;
        run_frame("underrun", 1, 1'b0, 1'b0, 24'h000000);
        check("ur_pulses", 32'(ur_count), 32'd1);
        check("ur_cycle", 32'(ur_cycle), 32'd576);
        check("ur_fd_cycle", 32'(fd_cycle), 32'd1076);
        check("ur_decoded", 32'(dec[0]), 32'h00123456);
        step();
        check("ur_idle_busy", 32'(busy), 32'd0);
        check("ur_idle_ready", 32'(word_ready), 32'd1);

        // ---------------- back-to-back frames ----------------
        fw[0] = 24'h0F0F0F;
        run_frame("b2b_a", 1, 1'b1, 1'b1, 24'hC3C3C3);
        check("b2b_a_fd_cycle", 32'(fd_cycle), 32'd1076);
        check("b2b_a_decoded", 32'(dec[0]), 32'h000F0F0F);
        step();
        // IDLE cycle right after frame_done: the waiting word is taken here.
        check("b2b_gap_busy", 32'(busy), 32'd0);
        check("b2b_gap_dout", 32'(dout), 32'd0);
        check("b2b_gap_ready", 32'(word_ready), 32'd1);
        fw[0] = 24'hC3C3C3;
        run_frame("b2b_b", 1, 1'b1, 1'b0, 24'h000000);
        check("b2b_b_first_rise", 32'(dout_log[1]), 32'd1);
        check("b2b_b_decoded", 32'(dec[0]), 32'h00C3C3C3);
        check("b2b_b_fd_cycle", 32'(fd_cycle), 32'd1076);
        step();

        // ---------------- reset mid-frame ----------------
        word_data  = 24'hA50F01;
        word_last  = 1'b1;
        word_valid = 1'b1;
        step();                       // handshake edge, now in cycle 1
        word_valid = 1'b0;
        repeat (319) step();          // cycle 320 lies in bit 10 (cycles 313..336)
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready_in_rst", 32'(word_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", 32'(word_ready), 32'd1);
        fd_seen = 0;
        hi_seen = 0;
        for (int t = 0; t < 1200; t++) begin
            step();
            if (frame_done === 1'b1) fd_seen++;
            if (dout !== 1'b0) hi_seen++;
        end
        check("midrst_no_frame_done", 32'(fd_seen), 32'd0);
        check("midrst_line_quiet", 32'(hi_seen), 32'd0);
        fw[0] = 24'h5A5A5A;
        run_frame("after_rst", 1, 1'b1, 1'b0, 24'h000000);
        check("after_rst_decoded", 32'(dec[0]), 32'h005A5A5A);
        check("after_rst_fd_cycle", 32'(fd_cycle), 32'd1076);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
